branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the pipelined RV32I core, split out of the core so predictor geometry and policy can change without touching pipeline RTL. The decode stage performs a combinational lookup; the execute stage returns the resolved direction. It provides a selectable gselect/gshare index with a 2-bit saturating-counter BHT cleared by a hardware sweep after reset, plus a return-address stack (RAS) whose pointer is checkpointed through the pipeline and restored on a flush.

---
 rtl/bp_pkg.sv | 22 ++
 rtl/bp_ras.sv | 56 +++++
 rtl/branch_predictor.sv | 92 +++++++++
 tb/tb_branch_predictor.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared constants, state encoding and index/counter helpers for the branch predictor.
package bp_pkg;
    localparam int MODE_GSELECT = 0;
    localparam int MODE_GSHARE = 1;
    localparam logic [1:0] CTR_INIT = 2'b01;

    typedef enum logic {INIT, RUN} bp_state_e;

    function automatic logic [1:0] incdec_sat(input logic [1:0] c, input logic taken);
        return taken ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
    endfunction

    // bh must arrive zero-extended; the caller truncates the result to addr_bits
    function automatic logic [31:0] bht_index(input logic [31:0] pc, input logic [31:0] bh,
                                              input int mode, input int addr_bits, input int hist_bits);
        logic [31:0] pw;
        logic [31:0] lo_mask;
        pw = pc >> 2;
        lo_mask = (32'd1 << (addr_bits - hist_bits)) - 32'd1;
        return (mode == MODE_GSHARE) ? (pw ^ bh) : ((bh << (addr_bits - hist_bits)) | (pw & lo_mask));
    endfunction
endpackage

// File: rtl/bp_ras.sv
// bp_ras: circular return-address stack with saturating occupancy and checkpoint restore on flush.
module bp_ras #(
    parameter int DEPTH = 8,
    localparam int P = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          lk_valid,
    input  logic [31:0]   lk_pc,
    input  logic          is_call,
    input  logic          is_ret,
    input  logic          flush,
    input  logic [P-1:0]  f_ptr,
    input  logic [P:0]    f_cnt,
    output logic [P-1:0]  ptr,
    output logic [P:0]    cnt,
    output logic [31:0]   top,
    output logic          valid
);
    logic [31:0] stack_q [DEPTH];
    logic [P-1:0] ptr_q, ptr_d, wr_idx;
    logic [P:0] cnt_q, cnt_d;
    logic push, pop, both, wr_en;

    always_comb begin
        push = lk_valid & is_call & ~is_ret;
        pop = lk_valid & is_ret & ~is_call & (cnt_q != '0);
        both = lk_valid & is_call & is_ret;
        ptr_d = flush ? f_ptr : push ? ptr_q + P'(1) : pop ? ptr_q - P'(1) : ptr_q;
        cnt_d = flush ? f_cnt
              : push ? ((cnt_q == (P+1)'(DEPTH)) ? cnt_q : cnt_q + (P+1)'(1))
              : pop ? cnt_q - (P+1)'(1) : cnt_q;
        // a squashed lookup must not disturb the stack either
        wr_en = ~flush & (push | both);
        wr_idx = push ? ptr_q + P'(1) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) stack_q[wr_idx] <= lk_pc + 32'd4;
    end

    assign ptr = ptr_q;
    assign cnt = cnt_q;
    assign top = stack_q[ptr_q];
    assign valid = cnt_q != '0;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: gselect/gshare 2-bit BHT with post-reset clearing sweep, plus return-address stack.
module branch_predictor import bp_pkg::*; #(
    parameter int BHT_ADDR_BITS = 12,
    parameter int HIST_BITS = 9,
    parameter int MODE = MODE_GSELECT,
    parameter int RAS_DEPTH = 8,
    localparam int RAS_PTR_BITS = $clog2(RAS_DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     busy,
    input  logic                     lk_valid,
    input  logic [31:0]              lk_PC,
    input  logic                     lk_isCall,
    input  logic                     lk_isRet,
    output logic                     lk_predict,
    output logic [BHT_ADDR_BITS-1:0] lk_index,
    output logic [RAS_PTR_BITS-1:0]  lk_ras_ptr,
    output logic [RAS_PTR_BITS:0]    lk_ras_cnt,
    output logic [31:0]              ras_top,
    output logic                     ras_valid,
    input  logic                     up_valid,
    input  logic [BHT_ADDR_BITS-1:0] up_index,
    input  logic                     up_taken,
    input  logic                     up_flush,
    input  logic [RAS_PTR_BITS-1:0]  up_ras_ptr,
    input  logic [RAS_PTR_BITS:0]    up_ras_cnt
);
    localparam int BHT_SIZE = 1 << BHT_ADDR_BITS;

    logic [1:0] bht_q [BHT_SIZE];
    bp_state_e state_q, state_d;
    logic [BHT_ADDR_BITS-1:0] sweep_q, sweep_d, wr_idx;
    logic [HIST_BITS-1:0] bh_q, bh_d;
    logic [1:0] wr_val;
    logic wr_en;

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        bh_d = bh_q;
        wr_en = 1'b0;
        wr_idx = up_index;
        wr_val = incdec_sat(bht_q[up_index], up_taken);
        if (state_q == INIT) begin
            wr_en = 1'b1;
            wr_idx = sweep_q;
            wr_val = CTR_INIT;
            sweep_d = sweep_q + BHT_ADDR_BITS'(1);
            state_d = (sweep_q == {BHT_ADDR_BITS{1'b1}}) ? RUN : INIT;
        end else if (up_valid) begin
            wr_en = 1'b1;
            bh_d = HIST_BITS'({bh_q, up_taken});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            sweep_q <= '0;
            bh_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            bh_q <= bh_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) bht_q[wr_idx] <= wr_val;
    end

    assign busy = state_q == INIT;
    assign lk_index = BHT_ADDR_BITS'(bht_index(lk_PC, 32'(bh_q), MODE, BHT_ADDR_BITS, HIST_BITS));
    assign lk_predict = ~busy & bht_q[lk_index][1];

    bp_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk(clk),
        .reset(reset),
        .lk_valid(lk_valid),
        .lk_pc(lk_PC),
        .is_call(lk_isCall),
        .is_ret(lk_isRet),
        .flush(up_flush),
        .f_ptr(up_ras_ptr),
        .f_cnt(up_ras_cnt),
        .ptr(lk_ras_ptr),
        .cnt(lk_ras_cnt),
        .top(ras_top),
        .valid(ras_valid)
    );
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench driving a gselect and a gshare instance with shared stimulus.
module tb_branch_predictor;
    localparam int S_BUSY0 = 0, S_PRED0 = 1, S_IDX0 = 2, S_PTR0 = 3, S_CNT0 = 4, S_TOP0 = 5, S_VAL0 = 6;
    localparam int S_BUSY1 = 7, S_PRED1 = 8, S_IDX1 = 9, S_PTR1 = 10, S_CNT1 = 11, S_TOP1 = 12, S_VAL1 = 13;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic lk_valid = 1'b0, lk_isCall = 1'b0, lk_isRet = 1'b0;
    logic [31:0] lk_PC = 32'h18;
    logic up_valid = 1'b0, up_taken = 1'b0, up_flush = 1'b0;
    logic [3:0] up_index = '0;
    logic [1:0] up_ras_ptr = '0;
    logic [2:0] up_ras_cnt = '0;
    logic busy0, pred0, val0, busy1, pred1, val1;
    logic [3:0] idx0, idx1;
    logic [1:0] ptr0, ptr1;
    logic [2:0] cnt0, cnt1;
    logic [31:0] top0, top1;

    always #5 clk = ~clk;

    branch_predictor #(.BHT_ADDR_BITS(4), .HIST_BITS(2), .MODE(0), .RAS_DEPTH(4)) u_gsel (
        .clk(clk), .reset(reset), .busy(busy0), .lk_valid(lk_valid), .lk_PC(lk_PC),
        .lk_isCall(lk_isCall), .lk_isRet(lk_isRet), .lk_predict(pred0), .lk_index(idx0),
        .lk_ras_ptr(ptr0), .lk_ras_cnt(cnt0), .ras_top(top0), .ras_valid(val0),
        .up_valid(up_valid), .up_index(up_index), .up_taken(up_taken), .up_flush(up_flush),
        .up_ras_ptr(up_ras_ptr), .up_ras_cnt(up_ras_cnt)
    );

    branch_predictor #(.BHT_ADDR_BITS(4), .HIST_BITS(2), .MODE(1), .RAS_DEPTH(4)) u_gshare (
        .clk(clk), .reset(reset), .busy(busy1), .lk_valid(lk_valid), .lk_PC(lk_PC),
        .lk_isCall(lk_isCall), .lk_isRet(lk_isRet), .lk_predict(pred1), .lk_index(idx1),
        .lk_ras_ptr(ptr1), .lk_ras_cnt(cnt1), .ras_top(top1), .ras_valid(val1),
        .up_valid(up_valid), .up_index(up_index), .up_taken(up_taken), .up_flush(up_flush),
        .up_ras_ptr(up_ras_ptr), .up_ras_cnt(up_ras_cnt)
    );

    typedef struct {
        string tag;
        int sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail = 0;
    logic [1:0] ctr_m [16];
    logic [1:0] bh_m = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_BUSY0: return 32'(busy0);
            S_PRED0: return 32'(pred0);
            S_IDX0:  return 32'(idx0);
            S_PTR0:  return 32'(ptr0);
            S_CNT0:  return 32'(cnt0);
            S_TOP0:  return top0;
            S_VAL0:  return 32'(val0);
            S_BUSY1: return 32'(busy1);
            S_PRED1: return 32'(pred1);
            S_IDX1:  return 32'(idx1);
            S_PTR1:  return 32'(ptr1);
            S_CNT1:  return 32'(cnt1);
            S_TOP1:  return top1;
            default: return 32'(val1);
        endcase
    endfunction

    task automatic want(input string tag, input int sel, input logic [31:0] exp);
        sb.push_back('{tag, sel, exp});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] pc, input logic c, input logic r);
        lk_valid = 1'b1;
        lk_PC = pc;
        lk_isCall = c;
        lk_isRet = r;
    endtask

    task automatic look_off();
        lk_valid = 1'b0;
        lk_isCall = 1'b0;
        lk_isRet = 1'b0;
    endtask

    function automatic logic [1:0] sat_m(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    // gshare lookup steered onto counter 5 using the modelled history
    task automatic look5();
        logic [3:0] p;
        p = 4'd5 ^ {2'b00, bh_m};
        look({26'd0, p, 2'b00}, 1'b0, 1'b0);
        want("gshare_idx5", S_IDX1, 32'd5);
        want("sat_pred", S_PRED1, 32'(ctr_m[5][1]));
    endtask

    task automatic upd(input logic [3:0] idx, input logic t);
        look5();
        up_valid = 1'b1;
        up_index = idx;
        up_taken = t;
        tick();
        up_valid = 1'b0;
        ctr_m[idx] = sat_m(ctr_m[idx], t);
        bh_m = {bh_m[0], t};
    endtask

    task automatic sweep_count(input int n_upd, output int n);
        bit done;
        done = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            up_valid = i < n_upd;
            up_index = 4'd1;
            up_taken = 1'b1;
            want("sweep_pred0", S_PRED0, 32'd0);
            want("sweep_pred1", S_PRED1, 32'd0);
            @(negedge clk);
            drain();
            if (busy0) n++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        up_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] pop_top [4];
        logic [2:0] pop_cnt [4];
        pop_top = '{32'h1034, 32'h1024, 32'h1014, 32'h1044};
        pop_cnt = '{3'd3, 3'd2, 3'd1, 3'd0};

        want("rst_busy", S_BUSY0, 32'd1);
        want("rst_pred", S_PRED0, 32'd0);
        want("rst_idx_gsel", S_IDX0, 32'b0010);
        want("rst_idx_gshare", S_IDX1, 32'b0110);
        want("rst_ptr", S_PTR0, 32'd0);
        want("rst_cnt", S_CNT0, 32'd0);
        want("rst_ras_valid", S_VAL0, 32'd0);
        want("rst_busy1", S_BUSY1, 32'd1);
        tick();
        tick();
        reset = 1'b0;
        look(32'h18, 1'b0, 1'b0);
        sweep_count(0, n);
        check("init_busy_cycles", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) ctr_m[i] = 2'b01;
        bh_m = '0;

        for (int i = 0; i < 4; i++) begin
            look(32'(i * 4), 1'b0, 1'b0);
            want("post_init_pred", S_PRED0, 32'd0);
            tick();
        end

        upd(4'd5, 1'b1);
        upd(4'd5, 1'b1);
        upd(4'd5, 1'b1);
        look5();
        tick();
        upd(4'd5, 1'b0);
        look5();
        tick();
        upd(4'd5, 1'b0);
        look5();
        tick();

        upd(4'd0, 1'b1);
        upd(4'd0, 1'b0);
        look(32'h18, 1'b0, 1'b0);
        want("idx_gselect", S_IDX0, 32'b1010);
        want("idx_gshare", S_IDX1, 32'b0100);
        tick();

        for (int i = 1; i <= 3; i++) begin
            look(32'(i * 32'h100), 1'b1, 1'b0);
            tick();
        end
        look_off();
        want("ras_top_3calls", S_TOP0, 32'h304);
        want("ras_cnt_3calls", S_CNT0, 32'd3);
        want("ras_valid_3calls", S_VAL0, 32'd1);
        tick();
        look(32'h500, 1'b0, 1'b1);
        tick();
        look_off();
        want("ras_top_ret", S_TOP0, 32'h204);
        want("ras_cnt_ret", S_CNT0, 32'd2);
        tick();
        for (int i = 0; i < 5; i++) begin
            look(32'h1000 + 32'(i * 16), 1'b1, 1'b0);
            tick();
        end
        look_off();
        want("ras_cnt_full", S_CNT0, 32'd4);
        want("ras_top_full", S_TOP0, 32'h1044);
        want("ras_cnt_full_u1", S_CNT1, 32'd4);
        want("ras_top_full_u1", S_TOP1, 32'h1044);
        tick();
        for (int i = 0; i < 5; i++) begin
            look(32'h600, 1'b0, 1'b1);
            tick();
            look_off();
            if (i < 4) begin
                want("ras_pop_top", S_TOP0, pop_top[i]);
                want("ras_pop_cnt", S_CNT0, 32'(pop_cnt[i]));
            end
            if (i >= 3) want("ras_pop_empty", S_VAL0, 32'd0);
            want("ras_pop_ptr", S_PTR0, (i < 3) ? 32'(2 - i) : 32'd3);
            tick();
        end
        want("ras_empty_u1", S_VAL1, 32'd0);
        want("ras_ptr_u1", S_PTR1, 32'd3);
        tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        look(32'h40, 1'b1, 1'b0);
        want("ckpt_ptr0", S_PTR0, 32'd0);
        want("ckpt_cnt0", S_CNT0, 32'd0);
        tick();
        look(32'h80, 1'b1, 1'b0);
        want("ckpt_ptr1", S_PTR0, 32'd1);
        want("ckpt_cnt1", S_CNT0, 32'd1);
        want("init_ras_top", S_TOP0, 32'h44);
        tick();
        look_off();
        up_flush = 1'b1;
        up_ras_ptr = 2'd0;
        up_ras_cnt = 3'd0;
        want("pre_flush_valid", S_VAL0, 32'd1);
        tick();
        want("flush_valid", S_VAL0, 32'd0);
        want("flush_cnt", S_CNT0, 32'd0);
        want("flush_ptr", S_PTR0, 32'd0);
        look(32'h100, 1'b1, 1'b0);
        up_ras_ptr = 2'd2;
        up_ras_cnt = 3'd1;
        tick();
        up_flush = 1'b0;
        look_off();
        want("flush_wins_ptr", S_PTR0, 32'd2);
        want("flush_wins_cnt", S_CNT0, 32'd1);
        tick();
        want("mid_sweep_busy", S_BUSY0, 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        look(32'h4, 1'b0, 1'b0);
        want("mid_rst_ras_valid", S_VAL0, 32'd0);
        sweep_count(3, n);
        check("mid_rst_busy_cycles", 32'(n), 32'd16);
        want("init_upd_ignored_idx0", S_IDX0, 32'd1);
        want("init_upd_ignored_idx1", S_IDX1, 32'd1);
        want("init_upd_ignored_pred", S_PRED0, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
